// File: rtl/mfcc_melbank_ctrl.sv
// Mel filterbank controller.
// For each filter it streams every spectrum bin through a three-stage pipeline:
// weight capture, weight*power product, then a saturating accumulate.
// The finished mel energy of each filter is presented on a valid/ready output.
module mfcc_melbank_ctrl #(
  parameter int NBINS  = 257,
  parameter int NFILT  = 26,
  parameter int SPEC_W = 32,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rom_sel,
  output logic [8:0]        rom_addr,
  input  logic [7:0]        rom_data,
  output logic              spec_rd_en,
  output logic [8:0]        spec_addr,
  input  logic [SPEC_W-1:0] spec_data,
  output logic              mel_valid,
  input  logic              mel_ready,
  output logic [ACC_W-1:0]  mel_data,
  output logic [4:0]        mel_idx
);

  localparam int PROD_W = 8 + SPEC_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [8:0] LAST_BIN  = 9'(NBINS - 1);
  localparam logic [4:0] LAST_FILT = 5'(NFILT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [4:0]        filt;
  logic [8:0]        bin;
  logic              drain_cnt;
  logic              accept;
  logic              handshake;
  logic              last_filt;

  logic [7:0]        w_p1;
  logic              vld_p1;
  logic [PROD_W-1:0] prod_p2;
  logic              vld_p2;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;

  // Unsigned add of a product into the accumulator, clamping to all-ones on
  // overflow. Once clamped, any further nonzero product overflows again, so
  // the saturated value sticks for the rest of the filter.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0]  a,
                                               input logic [PROD_W-1:0] b);
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] lim;
    s   = SUM_W'(a) + SUM_W'(b);
    lim = SUM_W'({ACC_W{1'b1}});
    if (s > lim) begin
      return {ACC_W{1'b1}};
    end
    return s[ACC_W-1:0];
  endfunction

  assign accept    = (state == IDLE) && start;
  assign handshake = (state == OUT) && mel_ready;
  assign last_filt = (filt == LAST_FILT);
  assign acc_sum   = vld_p2 ? sat_add(acc, prod_p2) : acc;

  assign rom_sel   = filt;
  assign rom_addr  = bin;
  assign spec_addr = bin;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: DRAIN waits two cycles so the last product lands in acc
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (bin == LAST_BIN) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = OUT;
      OUT:     if (mel_ready) state_nxt = last_filt ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy       = (state != IDLE);
    spec_rd_en = (state == RUN);
    mel_valid  = (state == OUT);
  end

  // Filter/bin counters; bin holds at its last value outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      bin  <= '0;
    end else if (accept) begin
      filt <= '0;
      bin  <= '0;
    end else if (state == RUN) begin
      if (bin != LAST_BIN) bin <= bin + 9'd1;
    end else if (handshake && !last_filt) begin
      filt <= filt + 5'd1;
      bin  <= '0;
    end
  end

  // DRAIN length counter and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= 1'b0;
      done      <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      done      <= handshake && last_filt;
    end
  end

  // Valid flags travelling with the pipeline data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= (state == RUN);
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1 -> 2: capture ROM weight alongside the spectrum read
  always_ff @(posedge clk) begin
    if (state == RUN) w_p1 <= rom_data;
  end

  // Stage 2 -> 3: weight times spectrum power
  always_ff @(posedge clk) begin
    if (vld_p1) prod_p2 <= PROD_W'(w_p1) * PROD_W'(spec_data);
  end

  // Stage 3: saturating accumulate, cleared at each filter start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept || handshake) begin
      acc <= '0;
    end else begin
      acc <= acc_sum;
    end
  end

  // Output holding register, loaded with the final sum as OUT is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mel_data <= '0;
      mel_idx  <= '0;
    end else if ((state == DRAIN) && drain_cnt) begin
      mel_data <= acc_sum;
      mel_idx  <= filt;
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_ctrl.sv
// Directed bench for mfcc_melbank_ctrl with NBINS=4, NFILT=2.
// Spectrum {1,2,3,4}; weights f0={1,1,0,0}, f1={0,0,2,1}:
//   mel0 = 1*1 + 1*2 = 3, mel1 = 2*3 + 1*4 = 10.
// Edge 0 is the start-accepting edge; mel_valid shows after edge NBINS+2 (=6),
// i.e. during the NBINS+3-th cycle, and done shows after edge 2*(NBINS+3) (=14).
module tb_mfcc_melbank_ctrl;

  localparam int NB = 4;
  localparam int NF = 2;
  localparam int SW = 32;
  localparam int AW = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [4:0]    rom_sel;
  logic [8:0]    rom_addr;
  logic [7:0]    rom_data;
  logic          spec_rd_en;
  logic [8:0]    spec_addr;
  logic [SW-1:0] spec_data = '0;
  logic          mel_valid;
  logic          mel_ready = 1'b1;
  logic [AW-1:0] mel_data;
  logic [4:0]    mel_idx;

  bit            sat_mode = 1'b0;
  logic [31:0]   spec_tab [0:3] = '{32'd1, 32'd2, 32'd3, 32'd4};
  logic [7:0]    w0_tab   [0:3] = '{8'd1, 8'd1, 8'd0, 8'd0};
  logic [7:0]    w1_tab   [0:3] = '{8'd0, 8'd0, 8'd2, 8'd1};

  int ntot = 0;
  int nbad = 0;

  mfcc_melbank_ctrl #(.NBINS(NB), .NFILT(NF), .SPEC_W(SW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .spec_rd_en(spec_rd_en), .spec_addr(spec_addr), .spec_data(spec_data),
    .mel_valid(mel_valid), .mel_ready(mel_ready), .mel_data(mel_data),
    .mel_idx(mel_idx)
  );

  always #5 clk = ~clk;

  // Combinational weight ROM model
  always_comb begin
    rom_data = 8'd0;
    if (sat_mode) rom_data = 8'hFF;
    else if (rom_sel == 5'd0) rom_data = w0_tab[rom_addr[1:0]];
    else if (rom_sel == 5'd1) rom_data = w1_tab[rom_addr[1:0]];
  end

  // Spectrum RAM model with one cycle read latency
  always @(posedge clk) begin
    if (spec_rd_en) spec_data <= sat_mode ? 32'hFFFF_FFFF : spec_tab[spec_addr[1:0]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from a start pulse until done (bounded at 60 edges).
  task automatic run_frame(input int stall, input bit poke,
                           output int done_at, output int vld_at, output int nhs,
                           output int first_idx, output logic [AW-1:0] m0,
                           output logic [AW-1:0] m1, output bit stall_ok,
                           output bit busy1);
    int stalled;
    done_at = -1; vld_at = -1; nhs = 0; first_idx = -1;
    m0 = '0; m1 = '0; stall_ok = 1'b1; busy1 = 1'b0; stalled = 0;
    start = 1'b1; mel_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      if (e == 1) busy1 = busy && spec_rd_en;
      start = poke && (e == 3);
      if (mel_valid && vld_at < 0) vld_at = e - 1;
      if (mel_valid && mel_idx == 5'd0 && stalled < stall) begin
        mel_ready = 1'b0;
        stalled++;
        if (spec_rd_en || mel_data != 40'd3) stall_ok = 1'b0;
      end else begin
        mel_ready = 1'b1;
      end
      if (mel_valid && mel_ready) begin
        nhs++;
        if (first_idx < 0) first_idx = int'(mel_idx);
        if (mel_idx == 5'd0) m0 = mel_data;
        else m1 = mel_data;
      end
      tick();
      if (done) begin
        done_at = e;
        break;
      end
    end
    start = 1'b0;
    mel_ready = 1'b1;
  endtask

  initial begin
    int da, va, nh, fi;
    logic [AW-1:0] m0, m1;
    bit sok, b1;

    // Reset values
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(mel_valid), 64'd0);
    chk("rst_rden", 64'(spec_rd_en), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_data", 64'(mel_data), 64'd0);
    rst_n = 1'b1;

    // Basic frame, first start right after reset release
    run_frame(0, 1'b0, da, va, nh, fi, m0, m1, sok, b1);
    chk("basic_busy_rden", 64'(b1), 64'd1);
    chk("basic_vld_edge", 64'(va), 64'd6);
    chk("basic_done_edge", 64'(da), 64'd14);
    chk("basic_nhs", 64'(nh), 64'd2);
    chk("basic_mel0", 64'(m0), 64'd3);
    chk("basic_mel1", 64'(m1), 64'd10);
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Stall OUT of filter 0 for 5 cycles
    tick();
    run_frame(5, 1'b0, da, va, nh, fi, m0, m1, sok, b1);
    chk("stall_stable_nord", 64'(sok), 64'd1);
    chk("stall_done_edge", 64'(da), 64'd19);
    chk("stall_mel0", 64'(m0), 64'd3);
    chk("stall_mel1", 64'(m1), 64'd10);

    // Start pulsed while busy must be ignored
    tick();
    run_frame(0, 1'b1, da, va, nh, fi, m0, m1, sok, b1);
    chk("poke_done_edge", 64'(da), 64'd14);
    chk("poke_nhs", 64'(nh), 64'd2);
    chk("poke_mel0", 64'(m0), 64'd3);
    chk("poke_mel1", 64'(m1), 64'd10);
    tick();
    chk("poke_idle", 64'(busy), 64'd0);

    // Saturation: 4 * 0xFF * 0xFFFFFFFF exceeds 40 bits
    sat_mode = 1'b1;
    run_frame(0, 1'b0, da, va, nh, fi, m0, m1, sok, b1);
    chk("sat_mel0", 64'(m0), 64'hFF_FFFF_FFFF);
    chk("sat_mel1", 64'(m1), 64'hFF_FFFF_FFFF);
    chk("sat_done_edge", 64'(da), 64'd14);
    sat_mode = 1'b0;
    tick();

    // Asynchronous reset in RUN of filter 1
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("pre_rst_sel", 64'(rom_sel), 64'd1);
    chk("pre_rst_rden", 64'(spec_rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sel", 64'(rom_sel), 64'd0);
    chk("mid_rst_addr", 64'(spec_addr), 64'd0);
    chk("mid_rst_rden", 64'(spec_rd_en), 64'd0);
    chk("mid_rst_data", 64'(mel_data), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (NB + 4) tick();
    chk("post_rst_valid", 64'(mel_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_frame(0, 1'b0, da, va, nh, fi, m0, m1, sok, b1);
    chk("post_rst_first_idx", 64'(fi), 64'd0);
    chk("post_rst_mel0", 64'(m0), 64'd3);
    chk("post_rst_mel1", 64'(m1), 64'd10);

    // Back-to-back: start in the cycle right after done
    tick();
    run_frame(0, 1'b0, da, va, nh, fi, m0, m1, sok, b1);
    chk("b2b_done_edge", 64'(da), 64'd14);
    chk("b2b_mel0", 64'(m0), 64'd3);
    chk("b2b_mel1", 64'(m1), 64'd10);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/mfcc_melbank_ctrl.md
MFCC_MELBANK_CTRL -- requirements
Module: mfcc_melbank_ctrl

Interface
REQ-001 Parameter NBINS, default 257: spectrum bins per frame, 2..512.
REQ-002 Parameter NFILT, default 26: mel filters per frame, 1..32.
REQ-003 Parameter SPEC_W, default 32: power-spectrum sample width, unsigned.
REQ-004 Parameter ACC_W, default 48: mel energy accumulator width, unsigned.
REQ-005 clk  input  1  sole clock; all flops are rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle frame start request.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse after the last filter handshake.
REQ-010 rom_sel  output  5  filter index that selects the external weight ROM.
REQ-011 rom_addr  output  9  bin address to the weight ROM.
REQ-012 rom_data  input  8  unsigned weight; combinational, valid in the same cycle as rom_addr.
REQ-013 spec_rd_en  output  1  spectrum RAM read strobe.
REQ-014 spec_addr  output  9  spectrum RAM bin address.
REQ-015 spec_data  input  SPEC_W  spectrum RAM data; valid one cycle after spec_rd_en.
REQ-016 mel_valid  output  1  mel_data and mel_idx are valid.
REQ-017 mel_ready  input  1  downstream accepts mel_data.
REQ-018 mel_data  output  ACC_W  accumulated filter energy.
REQ-019 mel_idx  output  5  filter index of mel_data.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN, OUT.
REQ-021 IDLE: start=1 moves to RUN, sets filt=0 and bin=0, clears acc, and sets busy=1 on the same edge.
REQ-022 start is ignored in every state except IDLE.
REQ-023 RUN, each cycle:
  - spec_rd_en=1
  - rom_addr=spec_addr=bin
  - rom_sel=filt
  - rom_data is registered into w_d, with valid stage v1 set
  - bin increments
  - after the cycle with bin=NBINS-1, go to DRAIN.
REQ-024 Stage 2: when v1 is set, prod <= w_d * spec_data, 8+SPEC_W bits, with valid stage v2 set.
REQ-025 Stage 3: when v2 is set, acc <= acc + prod.
  - acc is zero-extended to ACC_W.
  - On overflow, acc saturates to all-ones and stays there for that filter.
REQ-026 DRAIN lasts exactly 2 cycles so the last product reaches acc; it then goes to OUT.
REQ-027 OUT:
  - mel_valid=1, mel_data=acc, mel_idx=filt
  - these values stay stable until mel_valid and mel_ready are both high on a rising edge.
REQ-028 OUT handshake with filt<NFILT-1: filt increments, bin=0, acc clears, next state RUN in the next cycle.
REQ-029 OUT handshake with filt=NFILT-1: done pulses for 1 cycle, busy drops, next state IDLE.
REQ-030 spec_rd_en=0 in IDLE, DRAIN and OUT; rom_addr and spec_addr hold their last value there.
REQ-031 Latency: the first mel_valid rises NBINS+3 cycles after the start-accepting edge (260 for NBINS=257).
REQ-032 Per filter with mel_ready tied high: NBINS+3 cycles. Full frame: NFILT*(NBINS+3) cycles.
REQ-033 mel_ready low stalls in OUT indefinitely; no spectrum reads are issued while stalled.
REQ-034 mel_ready high outside OUT has no effect.
REQ-035 bin never exceeds NBINS-1; there is no address wrap within a filter.

Reset
REQ-036 rst_n low asynchronously forces:
  - state=IDLE
  - busy, done, mel_valid, spec_rd_en, v1, v2 = 0
  - filt, bin, rom_sel, rom_addr, spec_addr, acc, mel_data, mel_idx = 0.
REQ-037 Reset mid-frame abandons the frame; nothing is emitted after deassertion until a new start.
REQ-038 The first start is accepted on the first rising edge with rst_n high.

Verification
REQ-039 NBINS=4, NFILT=2; spectrum={1,2,3,4}; weights f0={1,1,0,0}, f1={0,0,2,1}; mel_ready=1.
  - Expect mel (idx0)=3 and (idx1)=10.
  - Expect done at cycle 14 after start.
REQ-040 Same setup with mel_ready=0 for 5 cycles during OUT of filter 0.
  - mel_data=3 holds stable throughout.
  - spec_rd_en=0 during the stall.
  - done is delayed by exactly 5 cycles.
REQ-041 SPEC_W=32, ACC_W=40, all spectrum=0xFFFFFFFF, all weights=0xFF.
  - Expect mel_data=0xFFFFFFFFFF (saturated) for every filter.
REQ-042 start pulsed again while busy.
  - Expect no restart and unchanged outputs.
  - Exactly NFILT mel_valid handshakes followed by one done.
REQ-043 rst_n pulled low mid-RUN of filter 1.
  - All outputs are 0 immediately.
  - After release and a new start, mel_idx begins at 0 with correct sums.
REQ-044 Back-to-back frames: start asserted in the cycle after done.
  - Accepted; the second frame's results match the first.
